// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg -- shared types and format helpers for the multi-cycle FP operators.
//
// Contents:
//   fp_format_e   supported IEEE-754 binary formats
//   roundmode_e   rounding modes (RISC-V frm encoding)
//   fflags_t      exception flags {NV, DZ, OF, UF, NX}
//   uround_res_t  unrounded result handed to fp_rnd: right-aligned
//                 {sign, exponent, fraction} plus {round, sticky}, the
//                 rounding mode to apply and any flags already decided
//   fp_width / exp_width / mant_width  per-format field widths
// -----------------------------------------------------------------------------
package fp_pkg;

    typedef enum logic [1:0] {
        FP16 = 2'd0,
        FP32 = 2'd1,
        FP64 = 2'd2
    } fp_format_e;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } roundmode_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    // Sized for the widest format; narrower formats sit in the low bits.
    localparam int MAX_FP_WIDTH = 64;

    typedef struct packed {
        logic [MAX_FP_WIDTH-1:0] u_result;
        logic [1:0]              rs;
        roundmode_e              rnd;
        fflags_t                 flags;
    } uround_res_t;

    function automatic int fp_width(input fp_format_e fmt);
        case (fmt)
            FP16:    return 16;
            FP64:    return 64;
            default: return 32;
        endcase
    endfunction

    function automatic int exp_width(input fp_format_e fmt);
        case (fmt)
            FP16:    return 5;
            FP64:    return 11;
            default: return 8;
        endcase
    endfunction

    function automatic int mant_width(input fp_format_e fmt);
        case (fmt)
            FP16:    return 10;
            FP64:    return 52;
            default: return 23;
        endcase
    endfunction

endpackage

// File: rtl/fp_sqrt.sv
// -----------------------------------------------------------------------------
// fp_sqrt -- iterative radix-2 floating-point square root, one root bit per
// cycle, producing an unrounded result for fp_rnd (start/done responder).
//
// Ports:
//   clk_i          clock, rising edge
//   reset_i        synchronous active-high reset
//   a_i            radicand, captured on an accepted start
//   start_i        start pulse, accepted only while idle
//   rnd_i          rounding mode, captured with a_i
//   urnd_result_o  unrounded result; valid from done_o until the next start
//   done_o         one-cycle completion pulse
//   busy_o         high from the accepted start through the done_o cycle
// -----------------------------------------------------------------------------
module fp_sqrt
    import fp_pkg::*;
#(
    parameter fp_format_e FP_FORMAT = FP32,
    localparam int        FP_WIDTH  = fp_width(FP_FORMAT)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [FP_WIDTH-1:0] a_i,
    input  logic                start_i,
    input  roundmode_e          rnd_i,
    output uround_res_t         urnd_result_o,
    output logic                done_o,
    output logic                busy_o
);

    localparam int EW   = exp_width(FP_FORMAT);
    localparam int MW   = mant_width(FP_FORMAT);
    localparam int BIAS = (2 ** (EW - 1)) - 1;
    localparam int RADW = MW + 3;          // radicand, two integer bits
    localparam int QW   = MW + 2;          // hidden + fraction + round bit
    localparam int RW   = MW + 5;          // signed partial remainder
    localparam int EXW  = EW + 2;          // signed unbiased exponent
    localparam int CW   = $clog2(QW);
    localparam int LZW  = $clog2(MW + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [FP_WIDTH-1:0] a_q, a_d;
    roundmode_e          rnd_q, rnd_d;
    logic [RADW-1:0]     rad_q, rad_d;
    logic [QW-1:0]       root_q, root_d;
    logic [RW-1:0]       rem_q, rem_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [EW-1:0]       exp_q, exp_d;
    uround_res_t         res_q, res_d;

    // ---------------- operand classification and normalisation ----------------
    logic                  sign;
    logic [EW-1:0]         exp_f;
    logic [MW-1:0]         frac;
    logic                  is_nan, is_snan, is_zero, is_inf, is_sub;
    logic                  is_special, special_nv;
    logic [FP_WIDTH-1:0]   special_val;
    logic [LZW-1:0]        lz, lz_p1;
    logic                  lz_found;
    logic [MW:0]           sig;
    logic signed [EXW-1:0] e_unb, e_even, e_half;
    logic                  e_odd;
    logic [RADW-1:0]       rad_init;
    logic [EW-1:0]         exp_res;

    always_comb begin
        sign  = a_q[FP_WIDTH-1];
        exp_f = a_q[FP_WIDTH-2 -: EW];
        frac  = a_q[MW-1:0];

        is_nan  = (&exp_f) & (|frac);
        is_snan = is_nan & ~frac[MW-1];
        is_inf  = (&exp_f) & ~(|frac);
        is_zero = ~(|exp_f) & ~(|frac);
        is_sub  = ~(|exp_f) & (|frac);

        // NaNs and any negative non-zero operand collapse to the canonical
        // NaN; ±0 and +inf pass through unchanged.
        is_special  = is_nan | is_zero | is_inf | sign;
        special_nv  = is_snan | (sign & ~is_zero & ~is_nan);
        special_val = a_q;
        if (is_nan | (sign & ~is_zero)) begin
            special_val = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
        end

        lz       = '0;
        lz_found = 1'b0;
        for (int i = MW - 1; i >= 0; i--) begin
            if (!lz_found) begin
                if (frac[i]) begin
                    lz_found = 1'b1;
                end else begin
                    lz = lz + LZW'(1);
                end
            end
        end
        lz_p1 = lz + LZW'(1);

        // A subnormal 0.f*2^(1-bias) becomes 1.x*2^(1-bias-(lz+1)).
        if (is_sub) begin
            sig   = {1'b0, frac} << lz_p1;
            e_unb = -EXW'(BIAS) - EXW'(lz);
        end else begin
            sig   = {1'b1, frac};
            e_unb = EXW'(exp_f) - EXW'(BIAS);
        end

        // Make the exponent even so it halves exactly; the radicand then
        // lies in [1,4) and the root in [1,2).
        e_odd    = e_unb[0];
        e_even   = e_unb - {{(EXW-1){1'b0}}, e_odd};
        e_half   = e_even >>> 1;
        exp_res  = EW'(e_half + EXW'(BIAS));
        rad_init = {1'b0, sig, 1'b0} << e_odd;
    end

    // ---------------- one non-restoring recurrence step ----------------
    logic [RW-1:0] rem_sh, rem_step, rem_fix;
    logic [QW-1:0] root_step;

    always_comb begin
        rem_sh = (rem_q << 2) | RW'(rad_q[RADW-1 -: 2]);
        if (rem_q[RW-1]) begin
            rem_step = rem_sh + RW'({root_q, 2'b11});
        end else begin
            rem_step = rem_sh - RW'({root_q, 2'b01});
        end
        root_step = {root_q[QW-2:0], ~rem_step[RW-1]};
        // A negative final remainder is restored to get the true one for
        // the sticky bit.
        if (rem_step[RW-1]) begin
            rem_fix = rem_step + RW'({root_step, 1'b1});
        end else begin
            rem_fix = rem_step;
        end
    end

    // ---------------- control ----------------
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        rnd_d   = rnd_q;
        rad_d   = rad_q;
        root_d  = root_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        res_d   = res_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    a_d     = a_i;
                    rnd_d   = rnd_i;
                    res_d   = '0;
                    state_d = PREP;
                end
            end
            PREP: begin
                if (is_special) begin
                    res_d                           = '0;
                    res_d.u_result[FP_WIDTH-1:0]    = special_val;
                    res_d.rnd                       = rnd_q;
                    res_d.flags.nv                  = special_nv;
                    state_d                         = DONE;
                end else begin
                    rad_d   = rad_init;
                    root_d  = '0;
                    rem_d   = '0;
                    cnt_d   = CW'(QW - 1);
                    exp_d   = exp_res;
                    state_d = ITER;
                end
            end
            ITER: begin
                rad_d  = rad_q << 2;
                root_d = root_step;
                rem_d  = rem_step;
                if (cnt_q == '0) begin
                    res_d                        = '0;
                    res_d.u_result[FP_WIDTH-1:0] = {1'b0, exp_q, root_step[QW-2:1]};
                    res_d.rs                     = {root_step[0], |rem_fix};
                    res_d.rnd                    = rnd_q;
                    state_d                      = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            rnd_q   <= RNE;
            rad_q   <= '0;
            root_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            rnd_q   <= rnd_d;
            rad_q   <= rad_d;
            root_q  <= root_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            res_q   <= res_d;
        end
    end

    assign urnd_result_o = res_q;
    assign done_o        = (state_q == DONE);
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_fp_sqrt.sv
// -----------------------------------------------------------------------------
// tb_fp_sqrt -- scoreboard bench for fp_sqrt (FP32).
// Stimulus pushes the hand-computed rounded result, flags and done cycle for
// each accepted operation; a monitor pops on every done_o, applies a small
// fp_rnd model to the unrounded output and compares.
// Cycle labels: the start is sampled at edge T; "cycle T+n" ends at edge T+n.
// -----------------------------------------------------------------------------
module tb_fp_sqrt;
    import fp_pkg::*;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [31:0] a_i;
    logic        start_i;
    roundmode_e  rnd_i;
    uround_res_t urnd_result_o;
    logic        done_o;
    logic        busy_o;

    fp_sqrt #(.FP_FORMAT(FP32)) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .a_i           (a_i),
        .start_i       (start_i),
        .rnd_i         (rnd_i),
        .urnd_result_o (urnd_result_o),
        .done_o        (done_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] res;
        logic        nv;
        logic        nx;
        int          done_cyc;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Reference rounding step, as fp_rnd applies it to {u_result, rs}.
    function automatic logic [31:0] rnd32(input logic [31:0] u, input logic [1:0] rs,
                                          input roundmode_e m);
        logic inc;
        case (m)
            RNE:     inc = rs[1] & (rs[0] | u[0]);
            RTZ:     inc = 1'b0;
            RDN:     inc = u[31] & (|rs);
            RUP:     inc = ~u[31] & (|rs);
            RMM:     inc = rs[1];
            default: inc = 1'b0;
        endcase
        return u + {31'd0, inc};
    endfunction

    // ---------------- monitor ----------------
    exp_t        mon_e;
    logic [31:0] mon_fin;
    logic [4:0]  mon_flags;

    always @(negedge clk) begin
        if (done_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got done_o=1 in cycle %0d, required none pending", cyc + 1);
            end else begin
                mon_e     = exp_q.pop_front();
                mon_fin   = rnd32(urnd_result_o.u_result[31:0], urnd_result_o.rs, urnd_result_o.rnd);
                mon_flags = {urnd_result_o.flags.nv, urnd_result_o.flags.dz, urnd_result_o.flags.of,
                             urnd_result_o.flags.uf, urnd_result_o.flags.nx | (|urnd_result_o.rs)};
                check({mon_e.tag, "_result"}, 64'(mon_fin), 64'(mon_e.res));
                check({mon_e.tag, "_flags"}, 64'(mon_flags), 64'({mon_e.nv, 3'b000, mon_e.nx}));
                check({mon_e.tag, "_done_cycle"}, 64'(cyc + 1), 64'(mon_e.done_cyc));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Caller is at a falling edge; start is sampled at the next rising edge.
    task automatic issue(input logic [31:0] a, input roundmode_e m, input bit push,
                         input logic [31:0] res, input logic nv, input logic nx,
                         input int lat, input string tag, output int t);
        exp_t e;
        a_i     = a;
        rnd_i   = m;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        t       = cyc;
        start_i = 1'b0;
        if (push) begin
            e.res      = res;
            e.nv       = nv;
            e.nx       = nx;
            e.done_cyc = t + lat;
            e.tag      = tag;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(input int limit, input string tag);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done_o === 1'b1) return;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL %s_timeout: got no done_o within %0d cycles, required done_o", tag, limit);
    endtask

    task automatic run_op(input logic [31:0] a, input roundmode_e m, input logic [31:0] res,
                          input logic nv, input logic nx, input int lat, input string tag);
        int t;
        @(negedge clk);
        issue(a, m, 1'b1, res, nv, nx, lat, tag, t);
        wait_done(40, tag);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t;
        reset_i = 1'b1;
        start_i = 1'b0;
        a_i     = '0;
        rnd_i   = RNE;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_done", 64'(done_o), 64'd0);
        check("reset_busy", 64'(busy_o), 64'd0);
        check("reset_result", 64'(urnd_result_o), 64'd0);
        reset_i = 1'b0;

        // 4.0 with busy window and exact latency
        @(negedge clk);
        issue(32'h4080_0000, RNE, 1'b1, 32'h4000_0000, 1'b0, 1'b0, 27, "sqrt4", t);
        for (int k = 1; k <= 28; k++) begin
            @(negedge clk);
            check($sformatf("sqrt4_busy_T+%0d", k), 64'(busy_o), 64'(k <= 27));
        end
        check("sqrt4_raw_u", urnd_result_o.u_result, 64'h4000_0000);
        check("sqrt4_raw_rs", 64'(urnd_result_o.rs), 64'd0);

        // 2.0 under three rounding modes; root bits end ...0011 round=0, sticky=1
        run_op(32'h4000_0000, RNE, 32'h3FB5_04F3, 1'b0, 1'b1, 27, "sqrt2_rne");
        check("sqrt2_raw_u", urnd_result_o.u_result, 64'h3FB5_04F3);
        check("sqrt2_raw_rs", 64'(urnd_result_o.rs), 64'd1);
        run_op(32'h4000_0000, RTZ, 32'h3FB5_04F3, 1'b0, 1'b1, 27, "sqrt2_rtz");
        run_op(32'h4000_0000, RUP, 32'h3FB5_04F4, 1'b0, 1'b1, 27, "sqrt2_rup");

        // specials
        run_op(32'hBF80_0000, RNE, 32'h7FC0_0000, 1'b1, 1'b0, 2, "neg_one");
        run_op(32'h8000_0000, RNE, 32'h8000_0000, 1'b0, 1'b0, 2, "neg_zero");
        run_op(32'h7F80_0000, RNE, 32'h7F80_0000, 1'b0, 1'b0, 2, "pos_inf");
        run_op(32'h7F80_0001, RNE, 32'h7FC0_0000, 1'b1, 1'b0, 2, "snan");

        // smallest subnormal: sqrt(2^-149) = sqrt(2) * 2^-75
        run_op(32'h0000_0001, RNE, 32'h1A35_04F3, 1'b0, 1'b1, 27, "min_sub");

        // 9.0 with an ignored start of 4.0 at T+5
        @(negedge clk);
        issue(32'h4110_0000, RNE, 1'b1, 32'h4040_0000, 1'b0, 1'b0, 27, "sqrt9_busy_start", t);
        repeat (4) @(posedge clk);
        #1;
        a_i     = 32'h4080_0000;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        wait_done(40, "sqrt9_busy_start");

        // aborted operation: reset during cycle T+10, no done_o may follow
        @(negedge clk);
        issue(32'h4000_0000, RNE, 1'b0, 32'h0, 1'b0, 1'b0, 0, "abort", t);
        repeat (9) @(posedge clk);
        #1;
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        @(negedge clk);
        check("abort_done", 64'(done_o), 64'd0);
        check("abort_busy", 64'(busy_o), 64'd0);
        check("abort_result", 64'(urnd_result_o), 64'd0);
        repeat (40) @(negedge clk);
        check("abort_idle_busy", 64'(busy_o), 64'd0);

        // back-to-back: result holds in the idle cycle, clears after the new start
        run_op(32'h4080_0000, RNE, 32'h4000_0000, 1'b0, 1'b0, 27, "b2b_first");
        @(negedge clk);
        check("b2b_hold", urnd_result_o.u_result, 64'h4000_0000);
        issue(32'h3F80_0000, RNE, 1'b1, 32'h3F80_0000, 1'b0, 1'b0, 27, "b2b_second", t);
        @(negedge clk);
        check("b2b_cleared", 64'(urnd_result_o), 64'd0);
        check("b2b_busy", 64'(busy_o), 64'd1);
        wait_done(40, "b2b_second");

        @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by 100000, required end of sequence");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fp_sqrt.md
# fp_sqrt

Iterative radix-2 floating-point square-root unit. It is the responder side of the start/done handshake used by the multi-cycle FP operators (same protocol as `fp_div`), so the existing control logic drives it unchanged. It produces an unrounded `uround_res_t` (mantissa plus round/sticky) for `fp_rnd`, just like the divider, with one root bit per cycle. Specials and subnormal inputs are handled internally.

## Interface
Parameters:
- `FP_FORMAT`, default `FP32`: `fp_format_e`; sets `FP_WIDTH`, `EXP_WIDTH` and `MANT_WIDTH` through the `fp_pkg` functions.

Ports:
- `clk_i`  in  1  clock; everything is synchronous to the rising edge.
- `reset_i`  in  1  reset; synchronous and active-high.
- `a_i`  in  `FP_WIDTH`  radicand; sampled only on an accepted start.
- `start_i`  in  1  start request; a one-cycle pulse.
- `rnd_i`  in  `roundmode_e`  rounding mode; captured together with `a_i`.
- `urnd_result_o`  out  `uround_res_t`  unrounded result for `fp_rnd`.
- `done_o`  out  1  one-cycle completion pulse.
- `busy_o`  out  1  high from the accepted start until `done_o`, inclusive.

## Operation
States: `IDLE`, `PREP`, `ITER`, `DONE`.

**IDLE**
- `start_i` = 1: capture `a_i` and `rnd_i`, then go to `PREP`.

**PREP** (one cycle): classify the captured operand.
- sNaN: canonical NaN, invalid set.
- qNaN: canonical NaN.
- Negative non-zero, including -inf: canonical NaN, invalid set.
- ±0: same-signed zero.
- +inf: +inf.
- Any of the special cases above: go directly to `DONE` with `rs` = 0.
- Otherwise:
  - Subnormal radicand: normalize it with a leading-zero count.
  - Compute the unbiased exponent `e`.
  - If `e` is odd, shift the significand left 1 and set `e` = `e` - 1.
  - Result exponent is `e/2 + bias`, an arithmetic shift.
  - Load the radicand register, width `MANT_WIDTH+3`, and clear the root and remainder.
  - Go to `ITER`.

**ITER**
- Runs `MANT_WIDTH+2` cycles; the counter counts down to 0.
- Each cycle is a non-restoring digit-recurrence step producing one root bit.
- Root bits are the hidden bit, `MANT_WIDTH` fraction bits and one round bit.
- When the counter reaches 0, go to `DONE`.

**DONE** (one cycle)
- Assert `done_o`.
- `u_result` = {sign 0, exponent, fraction}.
- `rs` = {round bit, sticky}, where sticky = remainder ≠ 0.
- Then return to `IDLE`.

**Arithmetic facts**
- The result is always normal for finite positive inputs, so OF and UF can never be flagged.
- The only flag that can occur for finite inputs is NX, which arises when `rs` ≠ 0.
- DZ is never raised.

## Timing
- **Reset:** `done_o` = 0, `busy_o` = 0, `urnd_result_o` = all zeros, state `IDLE`.
- **Reset mid-operation:** abort; outputs take their reset values on the next edge and no `done_o` is produced.
- **Start:** `start_i` is sampled at edge T.
  - Normal operand: `done_o` is high during cycle T+`MANT_WIDTH`+4, which is T+27 for FP32.
  - Special operand: `done_o` is high during cycle T+2.
- **Start while busy:** `start_i` while `busy_o` = 1, including the `DONE` cycle, is ignored and does not change the captured operands.
- **Result hold:** `urnd_result_o` is valid from the `done_o` cycle and holds until the next accepted start, which clears it to zero the following cycle.
- **Back-to-back:** a start on the cycle right after `done_o` is accepted.
- **Throughput:** one operation in flight; no pipelining.

## Test plan
Each scenario uses FP32 and is checked through `fp_rnd`.
1. a = `0x40800000` (4.0), RNE -> result `0x40000000`, flags 00000, `done_o` exactly at T+27, `busy_o` high for T+1..T+27.
2. a = `0x40000000` (2.0):
   - RNE and RTZ -> result `0x3FB504F3`, NX.
   - RUP -> result `0x3FB504F4`, NX.
3. Specials, each with `done_o` at T+2:
   - a = `0xBF800000` -> result `0x7FC00000`, NV.
   - a = `0x80000000` -> result `0x80000000`, no flags.
   - a = `0x7F800000` -> result `0x7F800000`, no flags.
   - a = `0x7F800001` -> result `0x7FC00000`, NV.
4. a = `0x00000001` (smallest subnormal), RNE -> result `0x1A3504F3`, NX.
5. Pulse `start_i` with a = `0x41100000` (9.0). Then:
   - At T+5, pulse `start_i` with a = `0x40800000`; that start is ignored and the result is `0x40400000`.
   - At T+10 of a second operation, assert `reset_i` for one cycle; no `done_o` follows and all outputs are zero.
6. Back-to-back: start on the cycle after `done_o` with a = `0x3F800000` -> result `0x3F800000`, no flags. The earlier result holds until that start is accepted.
